// File: rtl/instr_sram_ctrl.sv
// Instruction-fetch slave in front of a 1-cycle-latency single-port SRAM.
// Adds optional wait states and returns a bus error for addresses outside the window.
//
// state  | meaning
// S_IDLE | accepting requests; with no wait states the SRAM read issues in the grant cycle
// S_WAIT | counting down wait states; the read issues when the counter reaches 1
module instr_sram_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 16384,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         instr_req,
    input  logic [31:0]                  instr_addr,
    output logic                         instr_gnt,
    output logic [31:0]                  instr_rdata,
    output logic                         instr_err,
    output logic                         instr_valid,
    input  logic                         gnt_stall,
    output logic                         sram_ce,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    input  logic [31:0]                  sram_rdata
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [32:0] BASE_EXT  = {1'b0, ADDR_BASE};
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] lat_word;
    logic          lat_ok;
    logic          rsp_pend;
    logic          rsp_err;

    logic [32:0]   addr_ext;
    logic [32:0]   off;
    logic          in_range;
    logic [AW-1:0] cur_word;
    logic          issue;
    logic          issue_ok;

    // 33-bit window arithmetic so addresses near 32'hFFFF_FFFC cannot wrap into range
    always_comb begin
        addr_ext = {1'b0, instr_addr};
        off      = addr_ext - BASE_EXT;
        in_range = (addr_ext >= BASE_EXT) && (off < WIN_BYTES);
        cur_word = off[AW+1:2];
    end

    always_comb begin
        instr_gnt = reset_n && (state_q == S_IDLE) && instr_req && !gnt_stall;
        issue     = 1'b0;
        issue_ok  = 1'b0;
        sram_addr = cur_word;
        if (state_q == S_WAIT) begin
            sram_addr = lat_word;
            if (cnt_q == 4'd1) begin
                issue    = 1'b1;
                issue_ok = lat_ok;
            end
        end else if (instr_gnt && NO_WAIT) begin
            issue    = 1'b1;
            issue_ok = in_range;
        end
        sram_ce = issue && issue_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            lat_word <= '0;
            lat_ok   <= 1'b0;
            rsp_pend <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_pend <= issue;
            rsp_err  <= issue && !issue_ok;
            case (state_q)
                S_IDLE: begin
                    if (instr_gnt && !NO_WAIT) begin
                        lat_word <= cur_word;
                        lat_ok   <= in_range;
                        cnt_q    <= WAIT_LD;
                        state_q  <= S_WAIT;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Errored responses never expose whatever the SRAM output register last held
    always_comb begin
        instr_valid = rsp_pend;
        instr_err   = rsp_err;
        instr_rdata = (rsp_pend && !rsp_err) ? sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_instr_sram_ctrl.sv
// Bench for instr_sram_ctrl: four instances covering zero/two/three wait states and a high window base,
// directed scenarios followed by randomized traffic against a queue-based response model.
module tb_instr_sram_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req, stall, gnt, valid, err, ce;
    logic [31:0] addr [4];
    logic [31:0] rdata [4];
    logic [31:0] srd [4];
    logic [7:0]  sa [4];
    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
        logic [7:0]  word;
    } rsp_t;

    instr_sram_ctrl #(.ADDR_BASE(32'h0), .MEM_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[0]), .instr_addr(addr[0]), .instr_gnt(gnt[0]),
        .instr_rdata(rdata[0]), .instr_err(err[0]), .instr_valid(valid[0]), .gnt_stall(stall[0]),
        .sram_ce(ce[0]), .sram_addr(sa[0]), .sram_rdata(srd[0]));
    instr_sram_ctrl #(.ADDR_BASE(32'h0), .MEM_WORDS(256), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[1]), .instr_addr(addr[1]), .instr_gnt(gnt[1]),
        .instr_rdata(rdata[1]), .instr_err(err[1]), .instr_valid(valid[1]), .gnt_stall(stall[1]),
        .sram_ce(ce[1]), .sram_addr(sa[1]), .sram_rdata(srd[1]));
    instr_sram_ctrl #(.ADDR_BASE(32'h0), .MEM_WORDS(256), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[2]), .instr_addr(addr[2]), .instr_gnt(gnt[2]),
        .instr_rdata(rdata[2]), .instr_err(err[2]), .instr_valid(valid[2]), .gnt_stall(stall[2]),
        .sram_ce(ce[2]), .sram_addr(sa[2]), .sram_rdata(srd[2]));
    instr_sram_ctrl #(.ADDR_BASE(32'h8000_0000), .MEM_WORDS(256), .WAIT_CYCLES(0)) dut3 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[3]), .instr_addr(addr[3]), .instr_gnt(gnt[3]),
        .instr_rdata(rdata[3]), .instr_err(err[3]), .instr_valid(valid[3]), .gnt_stall(stall[3]),
        .sram_ce(ce[3]), .sram_addr(sa[3]), .sram_rdata(srd[3]));

    for (genvar g = 0; g < 4; g++) begin : g_sram
        always @(posedge clk) begin
            if (ce[g]) srd[g] <= mem[sa[g]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int k, input logic r, input logic [31:0] a, input logic s);
        @(posedge clk);
        #1;
        req[k] = r;
        addr[k] = a;
        stall[k] = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'hF;
        stall = 4'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if ({gnt[k], ce[k], valid[k], err[k]} !== 4'b0) begin failures++; $display("FAIL reset_ctrl[%0d]: got %b want 0000", k, {gnt[k], ce[k], valid[k], err[k]}); end
            checks++; if (rdata[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]); end
        end
        req = 4'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ((valid | gnt) !== 4'h0) begin failures++; $display("FAIL reset_release: got %b want 0000", valid | gnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(0, i < 4, 32'(i * 4), 1'b0);
            checks++; if (gnt[0] !== (i < 4)) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, gnt[0], i < 4); end
            checks++; if (ce[0] !== (i < 4)) begin failures++; $display("FAIL b2b_ce[%0d]: got %b want %b", i, ce[0], i < 4); end
            if (i < 4) begin
                checks++; if (sa[0] !== 8'(i)) begin failures++; $display("FAIL b2b_sram_addr[%0d]: got %0d want %0d", i, sa[0], i); end
            end
            checks++; if (valid[0] !== (i >= 1 && i <= 4)) begin failures++; $display("FAIL b2b_valid[%0d]: got %b", i, valid[0]); end
            if (i >= 1 && i <= 4) begin
                checks++; if (rdata[0] !== 32'((i - 1) * 4) || err[0] !== 1'b0) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h err %b want %h err 0", i, rdata[0], err[0], (i - 1) * 4); end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [6:0] eg, ec, ev;
        eg = 7'b0001001;
        ec = 7'b0100100;
        ev = 7'b1001000;
        for (int i = 0; i < 7; i++) begin
            drive(1, i < 4, (i == 0) ? 32'h10 : 32'h20, 1'b0);
            checks++; if (gnt[1] !== eg[i]) begin failures++; $display("FAIL ws_gnt[%0d]: got %b want %b", i, gnt[1], eg[i]); end
            checks++; if (ce[1] !== ec[i]) begin failures++; $display("FAIL ws_ce[%0d]: got %b want %b", i, ce[1], ec[i]); end
            checks++; if (valid[1] !== ev[i]) begin failures++; $display("FAIL ws_valid[%0d]: got %b want %b", i, valid[1], ev[i]); end
            if (i == 2 || i == 5) begin
                checks++; if (sa[1] !== ((i == 2) ? 8'd4 : 8'd8)) begin failures++; $display("FAIL ws_sram_addr[%0d]: got %0d", i, sa[1]); end
            end
            if (i == 3 || i == 6) begin
                checks++; if (rdata[1] !== ((i == 3) ? 32'h10 : 32'h20) || err[1] !== 1'b0) begin failures++; $display("FAIL ws_rdata[%0d]: got %h err %b", i, rdata[1], err[1]); end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            drive(0, i < 4, 32'h20, i < 3);
            if (i < 4) begin
                checks++; if (gnt[0] !== (i == 3)) begin failures++; $display("FAIL stall_gnt[%0d]: got %b want %b", i, gnt[0], i == 3); end
                checks++; if (ce[0] !== (i == 3)) begin failures++; $display("FAIL stall_ce[%0d]: got %b want %b", i, ce[0], i == 3); end
            end
            checks++; if (valid[0] !== (i == 4)) begin failures++; $display("FAIL stall_valid[%0d]: got %b want %b", i, valid[0], i == 4); end
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (valid[0] !== 1'b0) begin failures++; $display("FAIL stall_extra_valid: got %b want 0", valid[0]); end
    endtask

    task automatic test_stall_rdata();
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 32'h20, i < 3);
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (rdata[0] !== 32'h20 || err[0] !== 1'b0) begin failures++; $display("FAIL stall_rdata: got %h err %b want 20 err 0", rdata[0], err[0]); end
    endtask

    task automatic test_addr_window();
        logic [31:0] a_tab [4];
        logic [3:0]  ce_exp;
        a_tab[0] = 32'h7FFF_FFFC;
        a_tab[1] = 32'h8000_0400;
        a_tab[2] = 32'hFFFF_FFFC;
        a_tab[3] = 32'h8000_0008;
        ce_exp = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            drive(3, i < 4, a_tab[(i < 4) ? i : 0], 1'b0);
            if (i < 4) begin
                checks++; if (gnt[3] !== 1'b1) begin failures++; $display("FAIL win_gnt[%0d]: got %b want 1", i, gnt[3]); end
                checks++; if (ce[3] !== ce_exp[i]) begin failures++; $display("FAIL win_ce[%0d]: got %b want %b", i, ce[3], ce_exp[i]); end
            end
            if (i > 0) begin
                checks++; if (valid[3] !== 1'b1 || err[3] !== (i < 4)) begin failures++; $display("FAIL win_rsp[%0d]: got valid %b err %b want valid 1 err %b", i, valid[3], err[3], i < 4); end
                checks++; if (rdata[3] !== ((i < 4) ? 32'h0 : 32'h8)) begin failures++; $display("FAIL win_rdata[%0d]: got %h", i, rdata[3]); end
            end
        end
    endtask

    task automatic test_misaligned();
        drive(0, 1'b1, 32'h6, 1'b0);
        checks++; if (ce[0] !== 1'b1 || sa[0] !== 8'd1) begin failures++; $display("FAIL misalign_sram: got ce %b addr %0d want ce 1 addr 1", ce[0], sa[0]); end
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (valid[0] !== 1'b1 || rdata[0] !== 32'h4) begin failures++; $display("FAIL misalign_rdata: got valid %b data %h want 1 4", valid[0], rdata[0]); end
    endtask

    task automatic test_reset_midflight();
        drive(2, 1'b1, 32'h40, 1'b0);
        checks++; if (gnt[2] !== 1'b1) begin failures++; $display("FAIL mid_gnt: got %b want 1", gnt[2]); end
        drive(2, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (valid[2] !== 1'b0 || ce[2] !== 1'b0) begin failures++; $display("FAIL mid_in_reset: got valid %b ce %b want 0 0", valid[2], ce[2]); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (valid[2] !== 1'b0 || ce[2] !== 1'b0) begin failures++; $display("FAIL mid_stray[%0d]: got valid %b ce %b want 0 0", i, valid[2], ce[2]); end
        end
        drive(2, 1'b1, 32'h0, 1'b0);
        checks++; if (gnt[2] !== 1'b1) begin failures++; $display("FAIL mid_regnt: got %b want 1", gnt[2]); end
        for (int i = 1; i <= 4; i++) begin
            drive(2, 1'b0, 32'h0, 1'b0);
            checks++; if (valid[2] !== (i == 4)) begin failures++; $display("FAIL mid_latency[%0d]: got %b want %b", i, valid[2], i == 4); end
            checks++; if (ce[2] !== (i == 3)) begin failures++; $display("FAIL mid_ce[%0d]: got %b want %b", i, ce[2], i == 3); end
        end
        checks++; if (rdata[2] !== 32'h0 || err[2] !== 1'b0) begin failures++; $display("FAIL mid_rdata: got %h err %b want 0 0", rdata[2], err[2]); end
    endtask

    task automatic test_random(input int k, input int w, input logic [31:0] base, input int n);
        rsp_t q[$];
        int   next_free;
        next_free = 0;
        for (int c = 0; c < n + w + 3; c++) begin
            logic        r, s, exp_gnt, exp_ce;
            logic [31:0] a;
            logic [7:0]  exp_word;
            longint      off;
            rsp_t        e;
            r = (c < n) && ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0: a = base - 32'($urandom_range(1, 16));
                1: a = 32'hFFFF_FFFC;
                default: a = base + 32'($urandom_range(0, 1100));
            endcase
            drive(k, r, a, s);
            exp_gnt = r && !s && (c >= next_free);
            checks++; if (gnt[k] !== exp_gnt) begin failures++; $display("FAIL rnd%0d_gnt c=%0d: got %b want %b", k, c, gnt[k], exp_gnt); end
            if (exp_gnt) begin
                off = longint'(a) - longint'(base);
                e.due = c + w + 1;
                e.err = !(off >= 0 && off < 1024);
                e.word = 8'(off / 4);
                e.data = e.err ? 32'h0 : 32'(off / 4 * 4);
                q.push_back(e);
                next_free = c + w + 1;
            end
            exp_ce = 1'b0;
            exp_word = 8'h0;
            foreach (q[i]) begin
                if (q[i].due == c + 1 && !q[i].err) begin
                    exp_ce = 1'b1;
                    exp_word = q[i].word;
                end
            end
            checks++; if (ce[k] !== exp_ce) begin failures++; $display("FAIL rnd%0d_ce c=%0d: got %b want %b", k, c, ce[k], exp_ce); end
            if (exp_ce) begin
                checks++; if (sa[k] !== exp_word) begin failures++; $display("FAIL rnd%0d_sram_addr c=%0d: got %0d want %0d", k, c, sa[k], exp_word); end
            end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                checks++; if (valid[k] !== 1'b1) begin failures++; $display("FAIL rnd%0d_valid c=%0d: got %b want 1", k, c, valid[k]); end
                checks++; if (err[k] !== e.err || rdata[k] !== e.data) begin failures++; $display("FAIL rnd%0d_rsp c=%0d: got err %b data %h want err %b data %h", k, c, err[k], rdata[k], e.err, e.data); end
            end else begin
                checks++; if (valid[k] !== 1'b0) begin failures++; $display("FAIL rnd%0d_valid c=%0d: got %b want 0", k, c, valid[k]); end
            end
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd%0d_drain: got %0d outstanding want 0", k, q.size()); end
    endtask

    initial begin
        reset_n = 1'b0;
        req = 4'h0;
        stall = 4'h0;
        for (int k = 0; k < 4; k++) addr[k] = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4);
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_stall();
        test_stall_rdata();
        test_addr_window();
        test_misaligned();
        test_reset_midflight();
        test_random(0, 0, 32'h0, 400);
        test_random(1, 2, 32'h0, 400);
        test_random(2, 3, 32'h0, 400);
        test_random(3, 0, 32'h8000_0000, 400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sram_ctrl.md
Name: instr_sram_ctrl

Overview:
Instruction-side memory slave that sits directly upstream of the fetch stage. It services the req/gnt/valid instruction interface against a single-port synchronous SRAM macro that has 1-cycle read latency.
- Configurable wait states.
- Address-window checking that returns bus errors.
- A stall input so benches can exercise the master's grant-wait path.
- Responses are returned strictly in order, exactly one per grant.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of the first word of the instruction window.
MEM_WORDS, 16384, SRAM depth in 32-bit words; must be a power of two.
WAIT_CYCLES, 0, extra cycles inserted between grant and SRAM read; legal range 0..15.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
instr_req  input  1  fetch request from the fetch stage
instr_addr  input  32  fetch byte address; bits [1:0] ignored
instr_gnt  output  1  request accepted this cycle
instr_rdata  output  32  read data, qualified by instr_valid
instr_err  output  1  response error, qualified by instr_valid
instr_valid  output  1  response valid, one-cycle pulse per granted request
gnt_stall  input  1  forces instr_gnt low (test/arbitration hook)
sram_ce  output  1  SRAM read enable
sram_addr  output  $clog2(MEM_WORDS)  SRAM word address
sram_rdata  input  32  SRAM read data, valid the cycle after sram_ce

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low.
- Reset values: state=IDLE, wait counter=0, pending-response flags=0, latched address=0, instr_valid=0, instr_err=0.
- Combinational outputs hold these values under reset, since instr_req is ignored: instr_gnt=0, sram_ce=0, instr_rdata=0.
- Range check: in_range = (instr_addr >= ADDR_BASE) && (instr_addr - ADDR_BASE < MEM_WORDS*4). Compute in 33-bit arithmetic so there is no wrap at 32'hFFFF_FFFC.
- SRAM word address = (addr - ADDR_BASE) >> 2, truncated to the sram_addr width.
- FSM states: IDLE, WAIT.
  - IDLE: instr_gnt = instr_req & ~gnt_stall.
  - IDLE, on grant with WAIT_CYCLES==0: if in_range, sram_ce=1 and sram_addr driven combinationally from instr_addr in the same cycle. Stay in IDLE, so back-to-back grants give 1 response per cycle.
  - IDLE, on grant with WAIT_CYCLES>0: latch the word address and the in_range flag, load counter=WAIT_CYCLES, go to WAIT. No sram_ce this cycle.
  - WAIT: instr_gnt=0. The counter decrements each cycle.
  - WAIT, cycle in which counter==1: sram_ce = latched in_range, sram_addr = latched address. Next state is IDLE.
  - Throughput is one request per WAIT_CYCLES+1 cycles.
- Response pipeline: rsp_pend and rsp_err are registered in the cycle the read would issue, i.e. the grant cycle (WAIT_CYCLES==0) or the last WAIT cycle.
  - The next cycle: instr_valid=1, instr_err=rsp_err, instr_rdata = rsp_err ? 32'h0 : sram_rdata.
- Out-of-range request: still granted and still answered with identical latency. sram_ce stays 0, instr_err=1, instr_rdata=0.
- Latency from grant to instr_valid = WAIT_CYCLES+1 cycles, fixed. There is no backpressure on responses.
- At most one request is in flight for WAIT_CYCLES>0; at most one per cycle for WAIT_CYCLES==0.
- gnt_stall masks the grant only. It never delays or drops a response that is already in flight.
- instr_req is sampled only when instr_gnt=1. instr_addr changing while instr_req=1 and ungranted is legal; the value present in the grant cycle is used.
- The master flushing its fetch does not cancel anything: every granted request produces exactly one instr_valid pulse.
- Reset asserted mid-operation: any in-flight response is discarded with no instr_valid pulse, and the FSM returns to IDLE.

Test Plan:
1. WAIT_CYCLES=0, MEM preloaded word[i]=i*4; req held at addr 0,4,8,12 on consecutive cycles -> gnt every cycle, instr_valid in 4 consecutive cycles, rdata 0,4,8,12, err=0.
2. WAIT_CYCLES=2, single req at addr 32'h10 -> gnt cycle N, sram_ce at N+2 with sram_addr=4, instr_valid at N+3 with rdata=16. A req presented at N+1 is not granted until N+3.
3. gnt_stall=1 for 3 cycles with req=1 at addr 32'h20 -> gnt=0 for 3 cycles, gnt on the first cycle after stall drops, valid one cycle later with rdata=32'h20.
4. ADDR_BASE=32'h8000_0000, req at 32'h7FFF_FFFC, then 32'h8000_0000+MEM_WORDS*4, then 32'hFFFF_FFFC -> each granted, sram_ce=0, instr_valid with err=1, rdata=0. A following in-range req returns err=0.
5. Misaligned addr 32'h6 -> sram_addr=1, rdata=word[1]=32'h4.
6. WAIT_CYCLES=3: assert reset_n=0 in the second WAIT cycle, release, then req addr 0 -> no stray instr_valid after reset; the new request gets valid exactly 4 cycles after its grant.
